// File: rtl/port_decl_checker.sv
// port_decl_checker
//   Checks a stream of port declaration records for one module. Each record
//   names a port index and a kind (direction, variable, net). Duplicate or
//   conflicting declarations are reported as they arrive. After the final
//   record, every entry is scanned for a type without a direction. Then a
//   done pulse reports how many errors were handed off.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     record handshake
//   in_idx, in_kind       record port index and kind (0 dir, 1 var, 2 net, 3 rsvd)
//   in_last               record closes the module
//   err_valid/err_ready   error handshake
//   err_code, err_idx     error code (1..6) and the port index it refers to
//   done                  one-cycle pulse when the module check completes
//   err_count             errors reported for the module, valid with done
module port_decl_checker #(
  parameter int NUM_PORTS = 8,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [1:0]       in_kind,
  input  logic             in_last,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [2:0]       err_code,
  output logic [IDX_W-1:0] err_idx,
  output logic             done,
  output logic [7:0]       err_count
);

  localparam logic [2:0] DUP_DIR  = 3'd1;
  localparam logic [2:0] DUP_VAR  = 3'd2;
  localparam logic [2:0] DUP_NET  = 3'd3;
  localparam logic [2:0] VAR_NET  = 3'd4;
  localparam logic [2:0] NO_DIR   = 3'd5;
  localparam logic [2:0] BAD_KIND = 3'd6;

  localparam logic [IDX_W:0]   NP_EXT   = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {ACCEPT, REPORT, SCAN, DONE} state_t;

  state_t state_reg, state_next;

  logic [NUM_PORTS-1:0] has_dir_reg, has_var_reg, has_net_reg;
  logic [NUM_PORTS-1:0] sel_vec;
  logic [IDX_W-1:0]     scan_ptr_reg;
  logic [7:0]           count_reg;
  logic [2:0]           code_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 last_reg;
  // Held low through reset and set by the first clock edge after release,
  // so in_ready only rises on that edge.
  logic                 run_reg;

  logic       take, idx_ok, scan_bad, scan_adv, err_hs;
  logic [2:0] acc_code;

  assign take   = in_valid && in_ready;
  assign idx_ok = {1'b0, in_idx} < NP_EXT;
  assign err_hs = err_valid && err_ready;

  // One-hot select of the entry addressed by the incoming record.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_sel
      assign sel_vec[gi] = (in_idx == IDX_W'(gi));
    end
  endgenerate

  // Error classification of the incoming record against registered flags.
  always_comb begin
    acc_code = 3'd0;
    if (!idx_ok || in_kind == 2'd3) begin
      acc_code = BAD_KIND;
    end else begin
      case (in_kind)
        2'd0: if (has_dir_reg[in_idx]) acc_code = DUP_DIR;
        2'd1: begin
          if (has_var_reg[in_idx])      acc_code = DUP_VAR;
          else if (has_net_reg[in_idx]) acc_code = VAR_NET;
        end
        2'd2: begin
          if (has_net_reg[in_idx])      acc_code = DUP_NET;
          else if (has_var_reg[in_idx]) acc_code = VAR_NET;
        end
        default: acc_code = BAD_KIND;
      endcase
    end
  end

  // A typed entry without a direction stalls the scan until handed off.
  assign scan_bad = (has_var_reg[scan_ptr_reg] | has_net_reg[scan_ptr_reg])
                    & ~has_dir_reg[scan_ptr_reg];
  assign scan_adv = (state_reg == SCAN) && (!scan_bad || err_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ACCEPT;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCEPT: begin
        if (take) begin
          if (acc_code != 3'd0) state_next = REPORT;
          else if (in_last)     state_next = SCAN;
        end
      end
      REPORT: if (err_ready) state_next = last_reg ? SCAN : ACCEPT;
      SCAN:   if (scan_adv && scan_ptr_reg == LAST_IDX) state_next = DONE;
      DONE:   state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
  end

  // Outputs; err_code/err_idx are zero whenever no error is offered.
  always_comb begin
    in_ready  = run_reg && (state_reg == ACCEPT);
    err_valid = 1'b0;
    err_code  = 3'd0;
    err_idx   = '0;
    done      = (state_reg == DONE);
    err_count = count_reg;
    if (state_reg == REPORT) begin
      err_valid = 1'b1;
      err_code  = code_reg;
      err_idx   = idx_reg;
    end else if (state_reg == SCAN && scan_bad) begin
      err_valid = 1'b1;
      err_code  = NO_DIR;
      err_idx   = scan_ptr_reg;
    end
  end

  // Datapath: flags, captured error, scan pointer, error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg      <= 1'b0;
      has_dir_reg  <= '0;
      has_var_reg  <= '0;
      has_net_reg  <= '0;
      scan_ptr_reg <= '0;
      count_reg    <= 8'd0;
      code_reg     <= 3'd0;
      idx_reg      <= '0;
      last_reg     <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (state_reg == DONE) begin
        has_dir_reg <= '0;
        has_var_reg <= '0;
        has_net_reg <= '0;
        count_reg   <= 8'd0;
      end else begin
        // Flags are set on acceptance even when the record also errors.
        if (take && idx_ok) begin
          if (in_kind == 2'd0) has_dir_reg <= has_dir_reg | sel_vec;
          if (in_kind == 2'd1) has_var_reg <= has_var_reg | sel_vec;
          if (in_kind == 2'd2) has_net_reg <= has_net_reg | sel_vec;
        end
        if (err_hs && count_reg != 8'hFF) count_reg <= count_reg + 8'd1;
      end
      if (take && acc_code != 3'd0) begin
        code_reg <= acc_code;
        idx_reg  <= in_idx;
        last_reg <= in_last;
      end
      if (scan_adv) begin
        if (scan_ptr_reg == LAST_IDX) scan_ptr_reg <= '0;
        else                          scan_ptr_reg <= scan_ptr_reg + IDX_W'(1);
      end
    end
  end

endmodule

// File: doc/port_decl_checker.md
PORT_DECL_CHECKER -- requirements
Module: port_decl_checker

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, number of port table entries (2..256).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_PORTS), port index width.
REQ-003 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have in_valid  input  1  declaration record valid.
REQ-006 SHALL have in_ready  output  1  checker accepts the record this cycle.
REQ-007 SHALL have in_idx  input  IDX_W  port index of the record.
REQ-008 SHALL have in_kind  input  2  record kind: 0=direction, 1=variable, 2=net, 3=reserved.
REQ-009 SHALL have in_last  input  1  record is the final one of the module.
REQ-010 SHALL have err_valid  output  1  error record valid.
REQ-011 SHALL have err_ready  input  1  consumer accepts the error record.
REQ-012 SHALL have err_code  output  3  1=DUP_DIR, 2=DUP_VAR, 3=DUP_NET, 4=VAR_NET, 5=NO_DIR, 6=BAD_KIND.
REQ-013 SHALL have err_idx  output  IDX_W  port index the error refers to.
REQ-014 SHALL have done  output  1  one-cycle pulse when a module check completes.
REQ-015 SHALL have err_count  output  8  errors reported for the completed module; valid while done=1.

Function
REQ-016 SHALL keep per-entry flags has_dir, has_var, has_net.
REQ-017 SHALL implement FSM states ACCEPT, REPORT, SCAN, DONE.
REQ-018 ACCEPT: in_ready=1; a record is taken when in_valid && in_ready.
REQ-019 Kind 0 with has_dir set -> DUP_DIR; otherwise no error.
REQ-020 Kind 1: has_var set -> DUP_VAR; else has_net set -> VAR_NET; else no error.
REQ-021 Kind 2: has_net set -> DUP_NET; else has_var set -> VAR_NET; else no error.
REQ-022 Kind 3 -> BAD_KIND; flags unchanged.
REQ-023 At most one error per record, selected by the priority in REQ-019..022.
REQ-024 Kinds 0..2 SHALL set their flag in the same cycle as acceptance, whether or not an error is raised.
REQ-025 in_idx >= NUM_PORTS -> BAD_KIND; flags unchanged.
REQ-026 An error moves the FSM to REPORT on the next cycle: err_valid=1, err_code and err_idx held stable, in_ready=0.
REQ-027 REPORT exits on err_valid && err_ready: to SCAN if the erroring record had in_last, else to ACCEPT.
REQ-028 A record with in_last and no error goes directly to SCAN.
REQ-029 SCAN visits one entry per cycle, ascending from 0, with in_ready=0.
REQ-030 Any entry with has_var or has_net but not has_dir -> NO_DIR; the scan stalls on that entry until err_ready.
REQ-031 After entry NUM_PORTS-1 is resolved -> DONE.
REQ-032 DONE lasts one cycle: done=1, err_count presented, all flags and the counter cleared, then ACCEPT.
REQ-033 err_count SHALL increment on each err handshake and saturate at 255.
REQ-034 err_valid SHALL NOT deassert, and err_code/err_idx SHALL NOT change, until the handshake completes.
REQ-035 err_ready while err_valid=0 SHALL be ignored.
REQ-036 Flag updates are registered, so back-to-back records to the same index SHALL see the earlier record's flags.

Reset
REQ-037 rst_n=0 SHALL clear all flags and err_count and force state ACCEPT, immediately and regardless of clk.
REQ-038 During reset: in_ready=0, err_valid=0, done=0, err_code=0, err_idx=0.
REQ-039 Reset asserted mid-REPORT or mid-SCAN SHALL drop the pending error without a handshake.
REQ-040 in_ready SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-041 Records (0,dir),(0,dir) -> one error, code 1, idx 0.
REQ-042 Records (1,dir),(1,var),(1,var) -> code 2 idx 1; then (2,dir),(2,net),(2,net) -> code 3 idx 2; then (3,dir),(3,net),(3,var,last) -> code 4 idx 3; then done pulse with err_count=3.
REQ-043 Record (5,var,last) with no direction, err_ready held low 4 cycles -> err_valid stable code 5 idx 5 for 4 cycles; after the handshake, done with err_count=1.
REQ-044 Record (4,kind 3) -> code 6 idx 4; entry 4 flags remain clear (no NO_DIR reported at scan).
REQ-045 rst_n low during SCAN at entry 3 -> err_valid=0 immediately; after release, a fresh (0,dir,last) yields done with err_count=0.
REQ-046 300 duplicate-direction records, then last -> err_count saturates at 255.
